// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage miniRV pipeline: forwarding selects, load-use stall, redirect flushes.
// Decisions are combinational off a 3-entry destination shadow; ext_stall freezes the shadow and counters.
module hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_rf_we,
    input  logic             id_is_load,
    input  logic             id_valid,
    input  logic             ex_redirect,
    input  logic             ext_stall,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The load flag only matters while the producer sits in EX, so MEM/WB carry {we, rd} only.
    logic              r_ex_we;
    logic [RA_W-1:0]   r_ex_rd;
    logic              r_ex_ld;
    logic              r_mem_we;
    logic [RA_W-1:0]   r_mem_rd;
    logic              r_wb_we;
    logic [RA_W-1:0]   r_wb_rd;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_ex_w;
    logic              w_mem_w;
    logic              w_wb_w;
    logic              w_use1;
    logic              w_use2;
    logic              w_lu;
    logic              w_id_ex_flush;
    logic [1:0]        w_fwd1;
    logic [1:0]        w_fwd2;

    assign w_ex_w  = r_ex_we  & (r_ex_rd  != '0);
    assign w_mem_w = r_mem_we & (r_mem_rd != '0);
    assign w_wb_w  = r_wb_we  & (r_wb_rd  != '0);

    assign w_use1 = id_re1 & (id_rs1 != '0);
    assign w_use2 = id_re2 & (id_rs2 != '0);

    assign w_lu = r_ex_ld & w_ex_w &
                  ((w_use1 & (id_rs1 == r_ex_rd)) | (w_use2 & (id_rs2 == r_ex_rd)));

    assign w_id_ex_flush = ex_redirect | w_lu;

    function automatic logic [1:0] pick_src(
        input logic            used,
        input logic [RA_W-1:0] rs,
        input logic            ex_w,
        input logic [RA_W-1:0] ex_rd,
        input logic            mem_w,
        input logic [RA_W-1:0] mem_rd,
        input logic            wb_w,
        input logic [RA_W-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (ex_w && ex_rd == rs)
                sel = 2'b01;
            else if (mem_w && mem_rd == rs)
                sel = 2'b10;
            else if (wb_w && wb_rd == rs)
                sel = 2'b11;
        end
        return sel;
    endfunction

    assign w_fwd1 = pick_src(w_use1, id_rs1, w_ex_w, r_ex_rd, w_mem_w, r_mem_rd, w_wb_w, r_wb_rd);
    assign w_fwd2 = pick_src(w_use2, id_rs2, w_ex_w, r_ex_rd, w_mem_w, r_mem_rd, w_wb_w, r_wb_rd);

    // Outputs drop to zero the moment reset asserts, even in the middle of a freeze.
    always_comb begin
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        fwd1_sel    = 2'b00;
        fwd2_sel    = 2'b00;
        if (!rst_n) begin
            pc_hold = 1'b0;
        end else if (ext_stall) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
        end else begin
            pc_hold     = w_lu & ~ex_redirect;
            if_id_hold  = w_lu & ~ex_redirect;
            if_id_flush = ex_redirect;
            id_ex_flush = w_id_ex_flush;
            fwd1_sel    = w_fwd1;
            fwd2_sel    = w_fwd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_we     <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_ld     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_rd    <= '0;
            r_wb_we     <= 1'b0;
            r_wb_rd     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!ext_stall) begin
            r_wb_we  <= r_mem_we;
            r_wb_rd  <= r_mem_rd;
            r_mem_we <= r_ex_we;
            r_mem_rd <= r_ex_rd;
            if (w_id_ex_flush) begin
                r_ex_we <= 1'b0;
                r_ex_rd <= '0;
                r_ex_ld <= 1'b0;
            end else begin
                r_ex_we <= id_rf_we & id_valid;
                r_ex_rd <= id_rd;
                r_ex_ld <= id_is_load;
            end
            // A stall that coincides with a redirect is squashed, so it is not a real stall cycle.
            if (w_lu && !ex_redirect)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (ex_redirect)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_re1, id_re2, id_rf_we, id_is_load, id_valid, ex_redirect, ext_stall;
    logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic [31:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load), .id_valid(id_valid),
        .ex_redirect(ex_redirect), .ext_stall(ext_stall),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Reference: history of instructions that entered EX, newest first (index 0 = EX, 1 = MEM, 2 = WB).
    typedef struct { bit we; int rd; bit ld; } ins_t;
    ins_t        hist[$];
    logic [31:0] m_stall, m_flush;
    int          checks = 0;
    int          failures = 0;

    function automatic bit writes(ins_t e);
        return e.we && e.rd != 0;
    endfunction

    function automatic logic [1:0] m_fwd(int rs, bit re);
        if (!re || rs == 0) return 2'b00;
        for (int d = 0; d < 3; d++)
            if (writes(hist[d]) && hist[d].rd == rs) return 2'(d + 1);
        return 2'b00;
    endfunction

    function automatic bit m_lu();
        bit hit1, hit2;
        hit1 = id_re1 && id_rs1 != 0 && int'(id_rs1) == hist[0].rd;
        hit2 = id_re2 && id_rs2 != 0 && int'(id_rs2) == hist[0].rd;
        return hist[0].ld && writes(hist[0]) && (hit1 || hit2);
    endfunction

    task automatic m_reset();
        ins_t z;
        z = '{we: 1'b0, rd: 0, ld: 1'b0};
        hist = {z, z, z};
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic chk(string tag, string what, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input bit re1, input logic [4:0] rs2, input bit re2,
                         input logic [4:0] rd, input bit we, input bit ld, input bit redir, input bit stl);
        id_rs1 = rs1; id_re1 = re1; id_rs2 = rs2; id_re2 = re2;
        id_rd = rd; id_rf_we = we; id_is_load = ld; id_valid = 1'b1;
        ex_redirect = redir; ext_stall = stl;
    endtask

    // Compare every output against the model, then clock once and advance the model.
    task automatic cyc(string tag);
        bit   lu, squash;
        ins_t n;
        #1;
        lu = m_lu();
        squash = ex_redirect || lu;
        if (ext_stall) begin
            chk(tag, "pc_hold", pc_hold, 1);
            chk(tag, "if_id_hold", if_id_hold, 1);
            chk(tag, "if_id_flush", if_id_flush, 0);
            chk(tag, "id_ex_flush", id_ex_flush, 0);
            chk(tag, "fwd1", fwd1_sel, 0);
            chk(tag, "fwd2", fwd2_sel, 0);
        end else begin
            chk(tag, "pc_hold", pc_hold, 32'(lu && !ex_redirect));
            chk(tag, "if_id_hold", if_id_hold, 32'(lu && !ex_redirect));
            chk(tag, "if_id_flush", if_id_flush, 32'(ex_redirect));
            chk(tag, "id_ex_flush", id_ex_flush, 32'(squash));
            if (!ex_redirect) begin
                chk(tag, "fwd1", fwd1_sel, m_fwd(id_rs1, id_re1));
                chk(tag, "fwd2", fwd2_sel, m_fwd(id_rs2, id_re2));
            end
        end
        chk(tag, "stall_cnt", stall_cnt, m_stall);
        chk(tag, "flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        if (!ext_stall) begin
            if (lu && !ex_redirect) m_stall = m_stall + 1;
            if (ex_redirect) m_flush = m_flush + 1;
            if (squash) n = '{we: 1'b0, rd: 0, ld: 1'b0};
            else        n = '{we: id_rf_we && id_valid, rd: int'(id_rd), ld: id_is_load};
            hist.push_front(n);
            void'(hist.pop_back());
        end
        @(negedge clk);
    endtask

    initial begin
        m_reset();
        drive(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1, 0);
        #2;
        chk("reset", "pc_hold", pc_hold, 0);
        chk("reset", "if_id_flush", if_id_flush, 0);
        chk("reset", "id_ex_flush", id_ex_flush, 0);
        chk("reset", "stall_cnt", stall_cnt, 0);
        chk("reset", "flush_cnt", flush_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU dependency
        drive(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); cyc("t1_add");
        drive(5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0);
        #1; chk("t1", "fwd1", fwd1_sel, 2'b01); chk("t1", "fwd2", fwd2_sel, 2'b01);
        chk("t1", "pc_hold", pc_hold, 0);
        cyc("t1_sub");

        // Distance 2 and 3, then EX priority over MEM
        drive(5'd5, 1, 5'd0, 0, 5'd10, 1, 0, 0, 0);
        #1; chk("t2_d2", "fwd1", fwd1_sel, 2'b10); cyc("t2_d2");
        drive(5'd5, 1, 5'd0, 0, 5'd11, 1, 0, 0, 0);
        #1; chk("t2_d3", "fwd1", fwd1_sel, 2'b11); cyc("t2_d3");
        drive(5'd0, 0, 5'd0, 0, 5'd12, 1, 0, 0, 0); cyc("t2_gap");
        drive(5'd1, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0); cyc("t2_w2");
        drive(5'd0, 0, 5'd12, 1, 5'd13, 1, 0, 0, 0);
        #1; chk("t2_pri", "fwd2", fwd2_sel, 2'b01); cyc("t2_pri");

        // Load-use: one stall cycle, then MEM forwarding
        drive(5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0); cyc("t3_lw");
        drive(5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0);
        #1; chk("t3_stall", "pc_hold", pc_hold, 1); chk("t3_stall", "id_ex_flush", id_ex_flush, 1);
        cyc("t3_stall");
        #1; chk("t3_after", "fwd1", fwd1_sel, 2'b10); chk("t3_after", "pc_hold", pc_hold, 0);
        chk("t3_after", "stall_cnt", stall_cnt, 1);
        cyc("t3_after");

        // x0 writer and operand-less consumer
        drive(5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0); cyc("t4_x0w");
        drive(5'd0, 1, 5'd0, 1, 5'd14, 1, 0, 0, 0);
        #1; chk("t4_x0r", "fwd1", fwd1_sel, 2'b00); cyc("t4_x0r");
        drive(5'd1, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0); cyc("t4_lw");
        drive(5'd9, 0, 5'd9, 0, 5'd15, 1, 0, 0, 0);
        #1; chk("t4_lui", "pc_hold", pc_hold, 0); cyc("t4_lui");

        // Redirect alone, then redirect with a load-use match
        drive(5'd1, 1, 5'd2, 1, 5'd16, 1, 0, 1, 0);
        #1; chk("t5", "if_id_flush", if_id_flush, 1); chk("t5", "pc_hold", pc_hold, 0);
        cyc("t5_redir");
        chk("t5", "flush_cnt", flush_cnt, 1);
        drive(5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0); cyc("t5_lw");
        drive(5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 1, 0);
        #1; chk("t5_both", "if_id_hold", if_id_hold, 0); cyc("t5_both");
        chk("t5_both", "stall_cnt", stall_cnt, 1);

        // Freeze for three cycles, then resume
        drive(5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0); cyc("t6_w");
        drive(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc("t6_frz");
        ext_stall = 1'b0;
        #1; chk("t6_rel", "fwd1", fwd1_sel, 2'b01); cyc("t6_rel");

        // Reset pulse in the middle of a frozen load-use
        drive(5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0); cyc("t6_lw");
        drive(5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 1);
        #2; rst_n = 1'b0; #1;
        chk("t6_rst", "pc_hold", pc_hold, 0);
        chk("t6_rst", "if_id_hold", if_id_hold, 0);
        chk("t6_rst", "id_ex_flush", id_ex_flush, 0);
        chk("t6_rst", "fwd1", fwd1_sel, 0);
        chk("t6_rst", "stall_cnt", stall_cnt, 0);
        chk("t6_rst", "flush_cnt", flush_cnt, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ext_stall = 1'b0;
        cyc("t6_post");

        // Randomized traffic over a small register window so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 6)), 1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 6)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
            id_valid = 1'($urandom_range(0, 7) != 0);
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
